// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch (IF)
// and the load/store unit (LS). One transaction outstanding at a time; the
// winning request is latched in IDLE and replayed to memory as req/gnt/rvalid.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no transaction; arbitrate, pulse winner's gnt, latch request
// WAIT_GNT | mem_req high with latched attributes until mem_gnt
// WAIT_RSP | request accepted, waiting for mem_rvalid to return to owner
module mem_port_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    input  logic [DW/8-1:0] ls_be,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [DW-1:0]   ls_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            err
);

    localparam int BW = DW / 8;
    localparam int SW = $clog2(MAX_LS_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_ls_q;
    logic [SW-1:0] streak_q;
    logic          ls_win, if_win;
    logic          rsp_fire, spurious;

    // Arbitration: LS has priority unless IF has waited out a full LS streak
    always_comb begin
        ls_win = ls_req && !(if_req && (streak_q == STREAK_MAX));
        if_win = if_req && !ls_win;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (if_req || ls_req) state_d = WAIT_GNT;
            end
            WAIT_GNT: begin
                if (mem_gnt) state_d = mem_rvalid ? IDLE : WAIT_RSP;
            end
            WAIT_RSP: begin
                if (mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: grants, memory request, response routing, error detect
    always_comb begin
        if_gnt    = (state_q == IDLE) && if_win;
        ls_gnt    = (state_q == IDLE) && ls_win;
        mem_req   = (state_q == WAIT_GNT);
        rsp_fire  = ((state_q == WAIT_GNT) && mem_gnt && mem_rvalid) ||
                    ((state_q == WAIT_RSP) && mem_rvalid);
        if_rvalid = rsp_fire && !owner_ls_q;
        ls_rvalid = rsp_fire && owner_ls_q;
        if_rdata  = mem_rdata;
        ls_rdata  = mem_rdata;
        spurious  = mem_rvalid && ((state_q == IDLE) ||
                                   ((state_q == WAIT_GNT) && !mem_gnt));
    end

    // Latch the winning request; IF always reads a full word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_ls_q <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else if (ls_gnt) begin
            owner_ls_q <= 1'b1;
            mem_we     <= ls_we;
            mem_addr   <= ls_addr;
            mem_wdata  <= ls_wdata;
            mem_be     <= ls_be;
        end else if (if_gnt) begin
            owner_ls_q <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_be     <= {BW{1'b1}};
        end
    end

    // Count LS wins while IF is kept waiting; saturates at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else if (ls_gnt) begin
            if (!if_req)                     streak_q <= '0;
            else if (streak_q != STREAK_MAX) streak_q <= streak_q + 1'b1;
        end else if (if_gnt) begin
            streak_q <= '0;
        end
    end

    // Sticky flag for responses arriving when none is expected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        err <= 1'b0;
        else if (spurious) err <= 1'b1;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] ls_addr = '0, ls_wdata = '0;
    logic [3:0]  ls_be = '0;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_LS_STREAK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_ls;
        logic [31:0] data;
    } rsp_t;

    bit   gnt_q[$];
    rsp_t rsp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   gcount = 0;

    // memory model knobs
    int          gnt_lat = 0;
    int          rsp_lat = 1;
    bit          spur_req = 0;
    int          req_cnt = 0;
    bit          pending = 0;
    int          rsp_cnt = 0;
    logic [31:0] pend_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory model: fixed grant latency, response rsp_lat cycles after grant (0 = same cycle)
    initial begin
        forever begin
            @(posedge clk); #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                pending = 0;
                req_cnt = 0;
            end else if (spur_req) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'h0BAD_0BAD;
                spur_req   = 0;
            end else if (pending) begin
                if (rsp_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_data;
                    pending    = 0;
                end else begin
                    rsp_cnt--;
                end
            end else if (mem_req) begin
                if (req_cnt == gnt_lat) begin
                    mem_gnt = 1'b1;
                    req_cnt = 0;
                    if (rsp_lat == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem_data(mem_addr);
                    end else begin
                        pending   = 1;
                        rsp_cnt   = rsp_lat - 1;
                        pend_data = mem_data(mem_addr);
                    end
                end else begin
                    req_cnt++;
                end
            end
        end
    end

    // Scoreboard monitor: grants and responses compared against queued expectations
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_gnt || ls_gnt) begin
                if (if_gnt && ls_gnt) check("dual_gnt", 32'(if_gnt & ls_gnt), 32'd0);
                else if (gnt_q.size() == 0) check("unexpected_gnt", 32'(ls_gnt), 32'hFFFF_FFFF);
                else check("gnt_owner_ls", 32'(ls_gnt), 32'(gnt_q.pop_front()));
                gcount++;
            end
            if (if_rvalid || ls_rvalid) begin
                if (if_rvalid && ls_rvalid) check("dual_rvalid", 32'(if_rvalid & ls_rvalid), 32'd0);
                else if (rsp_q.size() == 0) check("unexpected_rvalid", 32'(ls_rvalid), 32'hFFFF_FFFF);
                else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check("rvalid_owner_ls", 32'(ls_rvalid), 32'(e.is_ls));
                    check("rdata", ls_rvalid ? ls_rdata : if_rdata, e.data);
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || gnt_q.size() != 0) && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        if (rsp_q.size() != 0 || gnt_q.size() != 0)
            check("drain_timeout", 32'(rsp_q.size() + gnt_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // One request; attributes on the memory side checked every cycle mem_req is high
    task automatic do_txn(input bit is_ls, input logic [31:0] addr, input bit we,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] exp_data);
        int n;
        bit got;
        @(posedge clk); #1;
        gnt_q.push_back(is_ls);
        rsp_q.push_back('{is_ls, exp_data});
        if (is_ls) begin
            ls_addr = addr; ls_we = we; ls_be = be; ls_wdata = wdata; ls_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        got = 0;
        n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            got = is_ls ? ls_gnt : if_gnt;
            @(posedge clk); #1;
            n++;
        end
        if (!got) check("gnt_timeout", 32'd0, 32'd1);
        ls_req = 1'b0;
        if_req = 1'b0;
        n = 0;
        while (rsp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            if (mem_req) begin
                check("txn_mem_addr", mem_addr, addr);
                check("txn_mem_we", 32'(mem_we), is_ls ? 32'(we) : 32'd0);
                check("txn_mem_be", 32'(mem_be), is_ls ? 32'(be) : 32'hF);
                check("txn_mem_wdata", mem_wdata, is_ls ? wdata : 32'd0);
            end
            n++;
        end
        drain();
    endtask

    initial begin
        int n;
        // reset state
        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_gnts", 32'({if_gnt, ls_gnt}), 32'd0);
        check("rst_rvalids", 32'({if_rvalid, ls_rvalid}), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_attr", 32'({mem_we, mem_be}) | mem_addr | mem_wdata, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // IF alone, exact timing: gnt t0, mem_req t1..t3, rvalid t4
        @(posedge clk); #1;
        gnt_lat = 2; rsp_lat = 1;
        if_addr = 32'h100; if_req = 1'b1;
        gnt_q.push_back(1'b0);
        rsp_q.push_back('{1'b0, 32'hDEADBEEF});
        #1;
        check("if_gnt_t0", 32'(if_gnt), 32'd1);
        check("if_mem_req_t0", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("if_mem_req_t1_3", 32'(mem_req), 32'd1);
            check("if_mem_addr", mem_addr, 32'h100);
            check("if_mem_be", 32'(mem_be), 32'hF);
            check("if_mem_we", 32'(mem_we), 32'd0);
            check("if_rvalid_early", 32'(if_rvalid), 32'd0);
        end
        @(negedge clk);
        check("if_mem_req_t4", 32'(mem_req), 32'd0);
        check("if_rvalid_t4", 32'(if_rvalid), 32'd1);
        check("if_rdata_t4", if_rdata, 32'hDEADBEEF);
        check("ls_rvalid_t4", 32'(ls_rvalid), 32'd0);
        drain();

        // simultaneous requests, zero-latency memory: LS first, then IF
        gnt_lat = 0; rsp_lat = 0;
        gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
        rsp_q.push_back('{1'b1, 32'h5A5A_0800});
        rsp_q.push_back('{1'b0, 32'h5A5A_0400});
        @(posedge clk); #1;
        if_addr = 32'h400; ls_addr = 32'h800; ls_we = 1'b0; ls_be = 4'hF;
        if_req = 1'b1; ls_req = 1'b1;
        n = 0;
        while ((if_req || ls_req) && n < 30) begin
            bit sl, si;
            @(negedge clk);
            sl = ls_gnt; si = if_gnt;
            @(posedge clk); #1;
            if (sl) ls_req = 1'b0;
            if (si) if_req = 1'b0;
            n++;
        end
        if (if_req || ls_req) check("sim_gnt_timeout", 32'({if_req, ls_req}), 32'd0);
        if_req = 1'b0; ls_req = 1'b0;
        drain();

        // starvation guard: LS,LS,LS,LS,IF,LS with both held high
        gnt_lat = 0; rsp_lat = 1;
        for (int i = 0; i < 6; i++) begin
            bit l;
            l = (i != 4);
            gnt_q.push_back(l);
            rsp_q.push_back('{l, l ? 32'h5A5A_0800 : 32'h5A5A_0400});
        end
        n = gcount;
        @(posedge clk); #1;
        if_req = 1'b1; ls_req = 1'b1;
        for (int c = 0; c < 100 && gcount < n + 6; c++) begin
            @(negedge clk); #1;
        end
        check("starve_grants", 32'(gcount - n), 32'd6);
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0;
        drain();

        // SB store to byte 3
        gnt_lat = 1; rsp_lat = 1;
        do_txn(1'b1, 32'h2003, 1'b1, 4'b1000, 32'hAA00_0000, 32'h5A5A_2003);

        // LS alone with if_req low clears the streak; IF still granted normally afterwards
        do_txn(1'b1, 32'h0040, 1'b0, 4'b0011, 32'h0, 32'h5A5A_0040);
        do_txn(1'b0, 32'h0044, 1'b0, 4'h0, 32'h0, 32'h5A5A_0044);

        // spurious response in IDLE sets sticky err
        check("err_before_spur", 32'(err), 32'd0);
        @(negedge clk);
        spur_req = 1;
        @(negedge clk);
        @(negedge clk);
        check("err_after_spur", 32'(err), 32'd1);
        do_txn(1'b0, 32'h0200, 1'b0, 4'h0, 32'h0, 32'h5A5A_0200);
        check("err_sticky", 32'(err), 32'd1);

        // reset while in WAIT_RSP abandons the transaction
        gnt_lat = 0; rsp_lat = 6;
        @(posedge clk); #1;
        if_addr = 32'h300; if_req = 1'b1;
        gnt_q.push_back(1'b0);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_in_wait_rsp", 32'(mem_req), 32'd0);
        rst_n = 1'b0;
        #1;
        rsp_q.delete();
        check("rst2_mem_req", 32'(mem_req), 32'd0);
        check("rst2_err", 32'(err), 32'd0);
        check("rst2_rvalids", 32'({if_rvalid, ls_rvalid}), 32'd0);
        check("rst2_mem_be", 32'(mem_be), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_mem_req", 32'(mem_req), 32'd0);
        check("post_rst_err", 32'(err), 32'd0);
        spur_req = 1;
        @(negedge clk);
        @(negedge clk);
        check("late_rvalid_err", 32'(err), 32'd1);
        check("queues_empty", 32'(gnt_q.size() + rsp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

endmodule
